// File: rtl/accum_window8.sv
// Sums N accepted 8-bit samples per window and presents the total on a valid/ready port.
// Result appears the cycle after the Nth handshake; input stalls (I_READY=0) while a result is held.
module accum_window8 #(
  parameter int N = 4,
  parameter int OUT_WIDTH = 10,
  localparam int CW = $clog2(N + 1)
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESET,
  input  logic [7:0]           I,
  input  logic                 I_VALID,
  output logic                 I_READY,
  input  logic                 CLR,
  output logic [OUT_WIDTH-1:0] O,
  output logic                 O_OVF,
  output logic                 O_VALID,
  input  logic                 O_READY,
  output logic [CW-1:0]        COUNT
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t               state;
  state_t               state_next;
  logic [OUT_WIDTH-1:0] acc;
  logic                 ovf;
  logic [CW-1:0]        cnt;
  logic [OUT_WIDTH:0]   sum;
  logic                 ovf_next;
  logic                 accept;
  logic                 last;

  assign I_READY  = (state == ACC);
  assign accept   = I_VALID & I_READY;
  assign last     = (cnt == LAST_IDX);
  // One extra bit catches the wrap of this single addition.
  assign sum      = {1'b0, acc} + (OUT_WIDTH + 1)'(I);
  assign ovf_next = ovf | sum[OUT_WIDTH];
  assign COUNT    = cnt;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) state <= ACC;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (CLR) begin
      state_next = ACC;
    end else begin
      case (state)
        ACC:     if (accept && last) state_next = HOLD;
        HOLD:    if (O_VALID && O_READY) state_next = ACC;
        default: state_next = ACC;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      acc     <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      O       <= '0;
      O_OVF   <= 1'b0;
      O_VALID <= 1'b0;
    end else if (CLR) begin
      // O/O_OVF keep their value; only the valid flag is dropped.
      acc     <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
      O_VALID <= 1'b0;
    end else if (accept) begin
      if (last) begin
        O       <= sum[OUT_WIDTH-1:0];
        O_OVF   <= ovf_next;
        O_VALID <= 1'b1;
        acc     <= '0;
        ovf     <= 1'b0;
        cnt     <= '0;
      end else begin
        acc <= sum[OUT_WIDTH-1:0];
        ovf <= ovf_next;
        cnt <= cnt + CW'(1);
      end
    end else if (O_VALID && O_READY) begin
      O_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accum_window8.sv
// Drives two accum_window8 instances (10-bit and 8-bit sums) with shared stimulus
// and compares every cycle against a window-sum reference model.
module tb_accum_window8;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_dat;
  logic       i_vld;
  logic       clr;
  logic       o_rdy;

  logic       ir_a, ov_a, ovf_a;
  logic [9:0] o_a;
  logic [2:0] cnt_a;
  logic       ir_b, ov_b, ovf_b;
  logic [7:0] o_b;
  logic [2:0] cnt_b;

  int checks = 0;
  int failures = 0;

  // Reference model state: plain integer window sums.
  int  m_sum;
  int  m_cnt;
  bit  m_hold;
  int  m_res;

  always #5 clk = ~clk;

  accum_window8 #(.N(N), .OUT_WIDTH(10)) dut_a (
    .CLK(clk), .ASYNCRESET(rst), .I(i_dat), .I_VALID(i_vld), .I_READY(ir_a),
    .CLR(clr), .O(o_a), .O_OVF(ovf_a), .O_VALID(ov_a), .O_READY(o_rdy), .COUNT(cnt_a)
  );

  accum_window8 #(.N(N), .OUT_WIDTH(8)) dut_b (
    .CLK(clk), .ASYNCRESET(rst), .I(i_dat), .I_VALID(i_vld), .I_READY(ir_b),
    .CLR(clr), .O(o_b), .O_OVF(ovf_b), .O_VALID(ov_b), .O_READY(o_rdy), .COUNT(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_i_ready", 32'(ir_a), 32'(!m_hold));
    chk("a_o_valid", 32'(ov_a), 32'(m_hold));
    chk("a_count",   32'(cnt_a), 32'(m_cnt));
    chk("a_o",       32'(o_a), 32'(m_res % 1024));
    chk("a_o_ovf",   32'(ovf_a), 32'(m_res > 1023));
    chk("b_i_ready", 32'(ir_b), 32'(!m_hold));
    chk("b_o_valid", 32'(ov_b), 32'(m_hold));
    chk("b_count",   32'(cnt_b), 32'(m_cnt));
    chk("b_o",       32'(o_b), 32'(m_res % 256));
    chk("b_o_ovf",   32'(ovf_b), 32'(m_res > 255));
  endtask

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_hold = 0; m_res = 0;
  endtask

  // Applies the clock-edge rules to the model using the inputs just presented.
  task automatic model_step();
    if (clr) begin
      m_sum = 0; m_cnt = 0; m_hold = 0;
    end else if (!m_hold) begin
      if (i_vld) begin
        m_sum += int'(i_dat);
        m_cnt++;
        if (m_cnt == N) begin
          m_res = m_sum; m_hold = 1; m_sum = 0; m_cnt = 0;
        end
      end
    end else if (o_rdy) begin
      m_hold = 0;
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit c, input bit r);
    i_vld = v; i_dat = d; clr = c; o_rdy = r;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_a_o_valid", 32'(ov_a), 0);
    chk("rst_a_o", 32'(o_a), 0);
    chk("rst_a_ovf", 32'(ovf_a), 0);
    chk("rst_a_count", 32'(cnt_a), 0);
    chk("rst_b_o", 32'(o_b), 0);
    chk("rst_b_ovf", 32'(ovf_b), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_vld = 0; i_dat = 0; clr = 0; o_rdy = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Back-to-back window with immediate consumption.
    cyc(1, 10, 0, 1); cyc(1, 20, 0, 1); cyc(1, 30, 0, 1); cyc(1, 40, 0, 1);
    cyc(1, 99, 0, 1); cyc(0, 0, 0, 1);

    // Backpressure while a result is held.
    cyc(1, 10, 0, 0); cyc(1, 20, 0, 0); cyc(1, 30, 0, 0); cyc(1, 40, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 7, 0, 0);
    cyc(1, 7, 0, 1); cyc(1, 7, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(0, 0, 0, 1);

    // Overflow in the 8-bit instance, then a clean window.
    cyc(1, 255, 0, 1); cyc(1, 255, 0, 1); cyc(1, 1, 0, 1); cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1); cyc(1, 1, 0, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

    // Valid gaps.
    cyc(1, 5, 0, 1); cyc(0, 77, 0, 1); cyc(0, 88, 0, 1); cyc(1, 6, 0, 1);
    cyc(0, 55, 0, 1); cyc(1, 7, 0, 1); cyc(1, 8, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

    // CLR mid-window with a sample present, then CLR in HOLD alongside O_READY.
    cyc(1, 3, 0, 1); cyc(1, 4, 0, 1); cyc(1, 9, 1, 1);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 3, 0, 0); cyc(1, 4, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 1, 1); cyc(0, 0, 0, 1);

    // Async reset mid-window and while holding.
    cyc(1, 50, 0, 1); cyc(1, 60, 0, 1);
    async_reset();
    cyc(0, 0, 0, 1);
    cyc(1, 11, 0, 0); cyc(1, 12, 0, 0); cyc(1, 13, 0, 0); cyc(1, 14, 0, 0);
    cyc(0, 0, 0, 0);
    async_reset();
    cyc(1, 21, 0, 1); cyc(1, 22, 0, 1); cyc(1, 23, 0, 1); cyc(1, 24, 0, 1);
    cyc(0, 0, 0, 1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
